// File: rtl/biu8_ctrl.sv
// 8-bit pad bus interface unit: DATA/DIR/STATUS register access with strobed pad cycles.
// Define BIU8_CTRL_IRQ_EN to add the change-detect flag and the irq output.
module biu8_ctrl #(
  parameter int unsigned STROBE_CYC = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cs,
  input  logic       we,
  input  logic [1:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       ready,
  output logic [7:0] data_o,
  output logic       wr_n,
  output logic       rd_n,
  output logic       en,
  output logic       sel,
  input  logic [7:0] data_i
`ifdef BIU8_CTRL_IRQ_EN
  ,
  output logic       irq
`endif
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR_LOW  = 3'd1;
  localparam logic [2:0] WR_HOLD = 3'd2;
  localparam logic [2:0] RD_LOW  = 3'd3;
  localparam logic [2:0] RD_CAP  = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;

  localparam logic [3:0] CNT_INIT = 4'(STROBE_CYC - 1);

  logic [2:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] rdata_q, rdata_d;
  logic [7:0] data_q, data_d;
  logic       ready_q, ready_d;
  logic       wr_n_q, wr_n_d;
  logic       rd_n_q, rd_n_d;
  logic       en_q, en_d;
  logic       sel_q, sel_d;
  logic       chg_bit;
  logic       busy;

  assign busy = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    data_d  = data_q;
    ready_d = 1'b0;
    wr_n_d  = wr_n_q;
    rd_n_d  = rd_n_q;
    en_d    = en_q;
    sel_d   = sel_q;
    unique case (state_q)
      IDLE: begin
        if (cs) begin
          unique case (addr)
            2'd0: begin
              cnt_d = CNT_INIT;
              if (we) begin
                state_d = WR_LOW;
                data_d  = wdata;
                en_d    = 1'b1;
                wr_n_d  = 1'b0;
              end else begin
                state_d = RD_LOW;
                rd_n_d  = 1'b0;
              end
            end
            2'd1: begin
              state_d = DONE;
              ready_d = 1'b1;
              if (we) sel_d = wdata[0];
              else    rdata_d = {7'b0, sel_q};
            end
            2'd2: begin
              state_d = DONE;
              ready_d = 1'b1;
              if (!we) rdata_d = {6'b0, chg_bit, busy};
            end
            default: begin
              state_d = DONE;
              ready_d = 1'b1;
              if (!we) rdata_d = 8'h00;
            end
          endcase
        end
      end
      WR_LOW: begin
        if (cnt_q == 4'd0) begin
          state_d = WR_HOLD;
          wr_n_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      WR_HOLD: begin
        state_d = DONE;
        en_d    = 1'b0;
        ready_d = 1'b1;
      end
      RD_LOW: begin
        if (cnt_q == 4'd0) begin
          state_d = RD_CAP;
          rd_n_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RD_CAP: begin
        state_d = DONE;
        ready_d = 1'b1;
        rdata_d = data_i;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 8'h00;
      data_q  <= 8'h00;
      ready_q <= 1'b0;
      wr_n_q  <= 1'b1;
      rd_n_q  <= 1'b1;
      en_q    <= 1'b0;
      sel_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      wr_n_q  <= wr_n_d;
      rd_n_q  <= rd_n_d;
      en_q    <= en_d;
      sel_q   <= sel_d;
    end
  end

`ifdef BIU8_CTRL_IRQ_EN
  logic [7:0] prev_q;
  logic       prev_vld_q;
  logic       chg_q, chg_d;
  logic       chg_set, chg_clr;

  // First capture after reset only seeds the compare register.
  assign chg_set = (state_q == RD_CAP) && prev_vld_q && (data_i != prev_q);
  assign chg_clr = (state_q == IDLE) && cs && we &&
                   (addr == 2'd2) && wdata[1];
  assign chg_d   = chg_set | (chg_q & ~chg_clr);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_q     <= 8'h00;
      prev_vld_q <= 1'b0;
      chg_q      <= 1'b0;
    end else begin
      chg_q <= chg_d;
      if (state_q == RD_CAP) begin
        prev_q     <= data_i;
        prev_vld_q <= 1'b1;
      end
    end
  end

  assign chg_bit = chg_q;
  assign irq     = chg_q;
`else
  assign chg_bit = 1'b0;
`endif

  assign rdata  = rdata_q;
  assign ready  = ready_q;
  assign data_o = data_q;
  assign wr_n   = wr_n_q;
  assign rd_n   = rd_n_q;
  assign en     = en_q;
  assign sel    = sel_q;

endmodule
